mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Avalon-MM master sequencer between CPU core and memory bus. Accepts one load/store request
//  from core control, drives address/read/write/byteenable/writedata, holds them through
//  waitrequest, returns lane-aligned, extended load data, and raises stall_o to the core FSM.
//  Enables byte/half/word LB/LBU/LH/LHU/LW/SB/SH/SW and waitrequest-correct stalling.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max consecutive waitrequest cycles before abort (only with MEM_BUS_TIMEOUT_EN)
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset_n_i      in   1   asynchronous, active-low reset
//  req_i          in   1   core requests access (level; sampled only in IDLE)
//  we_i           in   1   1 = store, 0 = load
//  size_i         in   2   mem_size_t: SIZE_BYTE/SIZE_HALF/SIZE_WORD
//  sign_ext_i     in   1   loads: 1 sign-extend, 0 zero-extend (ignored for word)
//  addr_i         in   32  byte address
//  wdata_i        in   32  store data, value in low bits
//  stall_o        out  1   core must hold state
//  done_o         out  1   one-cycle pulse: access complete
//  rdata_o        out  32  extended load data, valid when done_o, held until next done_o
//  misalign_o     out  1   one-cycle pulse: misaligned request rejected
//  err_o          out  1   one-cycle pulse: timeout abort (0 when MEM_BUS_TIMEOUT_EN undefined)
//  address_o      out  32  Avalon address, {addr_i[31:2],2'b00}
//  read_o         out  1   Avalon read
//  write_o        out  1   Avalon write
//  waitrequest_i  in   1   Avalon waitrequest
//  byteenable_o   out  4   Avalon byteenable
//  writedata_o    out  32  Avalon writedata, lane-replicated
//  readdata_i     in   32  Avalon readdata, valid in cycle read_o && !waitrequest_i
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0; read_o/write_o drop without waiting.
//  FSM IDLE -> BUS -> RESP -> IDLE.
//  IDLE: req_i && aligned -> latch addr/size/sign/we/wdata, go BUS. req_i && misaligned ->
//   misalign_o=1 one cycle, no bus access, stay IDLE. Misaligned: HALF addr[0]=1; WORD addr[1:0]!=0.
//  BUS: read_o=!we, write_o=we; address/byteenable/writedata from latched regs, stable while
//   waitrequest_i=1. waitrequest_i=0 -> transfer accepted; load captures readdata_i; go RESP.
//  RESP: done_o=1 one cycle, rdata_o updated; -> IDLE unconditionally. req_i ignored in RESP.
//  stall_o = (IDLE && req_i && aligned) || BUS. Min latency: req_i to done_o = 2 cycles.
//  byteenable: BYTE 4'b0001<<addr[1:0]; HALF addr[1]?4'b1100:4'b0011; WORD 4'b1111.
//  writedata: BYTE {4{wdata[7:0]}}; HALF {2{wdata[15:0]}}; WORD wdata. Little-endian lanes.
//  Load extract: lane = readdata >> (8*addr[1:0]); BYTE/HALF extended per sign_ext_i to 32 bits.
//  register_v0-style observers: none; block holds no architectural state.
// CONFIGURATION
//  MEM_BUS_TIMEOUT_EN defined: 8-bit+ counter of consecutive waitrequest cycles in BUS; reaching
//   TIMEOUT_CYCLES -> deassert read/write, err_o=1 one cycle, done_o=0, rdata_o unchanged, -> IDLE.
//   Counter clears on entering BUS.
//  Undefined: no counter; BUS waits indefinitely; err_o tied 0.
// STRUCTURE
//  Package codes: mem_size_t (SIZE_BYTE=0,SIZE_HALF=1,SIZE_WORD=2), bus_state_t (IDLE,BUS,RESP).
//  Sub-module mem_lane_align (combinational): size+addr[1:0] -> byteenable, writedata
//   replication, readdata extract/extend. FSM, latches, timeout counter stay in mem_bus_ctrl.
// TESTING
//  1 LW addr 0x1004, waitrequest=0, readdata 0xDEADBEEF -> address 0x1004, be 4'b1111,
//    done_o 2 cycles after req_i, rdata_o 0xDEADBEEF.
//  2 LB addr 0x1003 sign, readdata 0x80FFFFFF -> be 4'b1000, rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  3 SH addr 0x2002 wdata 0x0000ABCD, waitrequest high 3 cycles -> write_o held 4 cycles,
//    be 4'b1100, writedata 0xABCDABCD stable, stall_o high throughout, then done_o.
//  4 LW addr 0x1002 -> misalign_o pulse, read_o never asserted, stall_o 0.
//  5 reset_n_i low mid-BUS with waitrequest high -> read_o/stall_o 0 same cycle, IDLE after release.
//  6 MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> err_o pulse, read_o drops, no done_o.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_ctrl_pkg
// Purpose : Shared type codes and helpers for the memory bus sequencer.
//           mem_size_t  - access width code carried from core to bus
//           bus_state_t - sequencer state encoding
//           is_misaligned() - alignment rule for a given width/offset
// Revision: 1.0 - initial release
// ============================================================================
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    // The timeout counter is never narrower than this.
    localparam int c_cnt_min_w = 8;

    // Bytes are always aligned; halves need addr[0]=0; words (and the
    // unused code 3, which behaves as a word) need addr[1:0]=0.
    function automatic logic is_misaligned(input mem_size_t size,
                                           input logic [1:0] addr_lo);
        logic r;
        case (size)
            SIZE_BYTE: r = 1'b0;
            SIZE_HALF: r = addr_lo[0];
            default:   r = (addr_lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_ctrl_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_align
// Purpose : Combinational byte-lane steering for a 32-bit little-endian bus.
//           i_size, i_addr_lo -> o_byteenable
//           i_wdata           -> o_writedata (value replicated into all lanes)
//           i_rdata           -> o_rdata_ext (lane extracted, sign/zero ext.)
//           i_sign_ext selects sign extension for byte/half loads.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_bus_ctrl_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_writedata,
    output logic [31:0] o_rdata_ext
);

    // Addressed lane moved down to bit 0; for words the offset is 0.
    logic [31:0] w_rshift;
    assign w_rshift = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_byteenable = 4'b1111;
        o_writedata  = i_wdata;
        o_rdata_ext  = w_rshift;
        case (i_size)
            SIZE_BYTE: begin
                o_byteenable = 4'b0001 << i_addr_lo;
                o_writedata  = {4{i_wdata[7:0]}};
                o_rdata_ext  = {{24{i_sign_ext & w_rshift[7]}}, w_rshift[7:0]};
            end
            SIZE_HALF: begin
                o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_writedata  = {2{i_wdata[15:0]}};
                o_rdata_ext  = {{16{i_sign_ext & w_rshift[15]}}, w_rshift[15:0]};
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_ctrl
// Purpose : Avalon-MM master sequencer for core load/store requests.
//           IDLE -> BUS -> RESP -> IDLE; holds the bus request through
//           waitrequest and returns lane-aligned, extended load data.
// Ports   : clk, reset_n_i (async, active-low)
//           core side : req_i we_i size_i sign_ext_i addr_i wdata_i ->
//                       stall_o done_o rdata_o misalign_o err_o
//           bus side  : address_o read_o write_o byteenable_o writedata_o,
//                       waitrequest_i readdata_i
// Config  : MEM_BUS_TIMEOUT_EN - when defined, aborts a bus access after
//           TIMEOUT_CYCLES consecutive waitrequest cycles and pulses err_o.
//           When undefined the bus waits indefinitely and err_o is 0.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic [31:0] address_o,
    output logic        read_o,
    output logic        write_o,
    input  logic        waitrequest_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    input  logic [31:0] readdata_i
);

    bus_state_t  r_state;
    bus_state_t  w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    mem_size_t   r_size;
    logic        r_sign;
    logic        r_we;

    logic        w_misaligned;
    logic        w_accept;
    logic        w_xfer_done;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_rext;

    assign w_misaligned = is_misaligned(mem_size_t'(size_i), addr_i[1:0]);
    assign w_accept     = (r_state == IDLE) && req_i && !w_misaligned;
    assign w_xfer_done  = (r_state == BUS) && !waitrequest_i;

    // Lane steering always works from the latched request so the bus
    // outputs stay stable while the core changes its inputs.
    mem_lane_align u_align (
        .i_size       (r_size),
        .i_addr_lo    (r_addr[1:0]),
        .i_sign_ext   (r_sign),
        .i_wdata      (r_wdata),
        .i_rdata      (readdata_i),
        .o_byteenable (w_be),
        .o_writedata  (w_wd),
        .o_rdata_ext  (w_rext)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int c_limit = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int c_cnt_w = ($clog2(c_limit + 1) > c_cnt_min_w) ?
                             $clog2(c_limit + 1) : c_cnt_min_w;

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_err;

    // The abort fires on the c_limit-th consecutive waitrequest cycle; the
    // FSM leaves BUS on that edge and err_o pulses in the following cycle,
    // when read/write are already low.
    assign w_timeout = (r_state == BUS) && waitrequest_i &&
                       (r_wait_cnt == c_cnt_w'(c_limit - 1));

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_accept) begin
                r_wait_cnt <= '0;
            end else if ((r_state == BUS) && waitrequest_i) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        misalign_o   = 1'b0;
        read_o       = 1'b0;
        write_o      = 1'b0;
        address_o    = '0;
        byteenable_o = '0;
        writedata_o  = '0;
        case (r_state)
            IDLE: begin
                stall_o    = w_accept;
                misalign_o = req_i && w_misaligned;
                if (w_accept) begin
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                stall_o      = 1'b1;
                read_o       = !r_we;
                write_o      = r_we;
                address_o    = {r_addr[31:2], 2'b00};
                byteenable_o = w_be;
                writedata_o  = w_wd;
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else if (w_xfer_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------- request latches
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= SIZE_BYTE;
            r_sign  <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_size  <= mem_size_t'(size_i);
                r_sign  <= sign_ext_i;
                r_we    <= we_i;
            end
            // Load data is captured on the accepting bus cycle so it is
            // already visible in RESP alongside done_o.
            if (w_xfer_done && !r_we) begin
                r_rdata <= w_rext;
            end
        end
    end

    assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_ctrl
// Purpose : Self-checking bench for mem_bus_ctrl. Directed and randomized
//           load/store accesses are compared against an arithmetic model of
//           lane enables, replication and load extraction.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sign_ext_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        err_o;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic        waitrequest_i;
    logic [3:0]  byteenable_o;
    logic [31:0] writedata_o;
    logic [31:0] readdata_i;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] model_rdata = '0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .size_i        (size_i),
        .sign_ext_i    (sign_ext_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .misalign_o    (misalign_o),
        .err_o         (err_o),
        .address_o     (address_o),
        .read_o        (read_o),
        .write_o       (write_o),
        .waitrequest_i (waitrequest_i),
        .byteenable_o  (byteenable_o),
        .writedata_o   (writedata_o),
        .readdata_i    (readdata_i)
    );

    // ------------------------------------------------------------- model
    // sz: 0 byte, 1 half, 2 word
    function automatic logic m_misaligned(int sz, logic [31:0] a);
        return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(int sz, logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(int sz, logic [31:0] w);
        if (sz == 0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(int sz, bit sg, logic [31:0] a,
                                           logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a % 4));
        if (sz == 0) begin
            v = v & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = v & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    // One complete access, entered and left at a falling edge with the DUT
    // idle. waits = number of waitrequest-high cycles before acceptance.
    task automatic do_access(input bit we, input int sz, input bit sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int waits, input logic [31:0] rd,
                             input string tag);
        logic        mis;
        logic [72:0] act_v;
        logic [72:0] exp_v;
        mis = m_misaligned(sz, a);
        req_i = 1'b1; we_i = we; size_i = 2'(sz); sign_ext_i = sg;
        addr_i = a; wdata_i = wd; waitrequest_i = 1'b1;
        #1;
        n_total++;
        if ({stall_o, misalign_o, read_o, write_o} !== {!mis, mis, 2'b00})
            $display("FAIL %s request: stall/mis/rd/wr got %b want %b", tag,
                     {stall_o, misalign_o, read_o, write_o}, {!mis, mis, 2'b00});
        else n_pass++;
        @(posedge clk); @(negedge clk);
        // Scramble core inputs: the DUT must work from its latched copy.
        req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom;
        size_i = 2'($urandom_range(0, 2)); we_i = ~we; sign_ext_i = ~sg;
        if (mis) begin
            #1;
            n_total++;
            if ({read_o, write_o, stall_o, misalign_o, done_o} !== 5'b0)
                $display("FAIL %s misalign after: rd/wr/stall/mis/done got %b want 00000",
                         tag, {read_o, write_o, stall_o, misalign_o, done_o});
            else n_pass++;
            return;
        end
        for (int j = 0; j <= waits; j++) begin
            waitrequest_i = (j < waits);
            readdata_i    = (j < waits) ? $urandom : rd;
            #1;
            act_v = {read_o, write_o, stall_o, done_o, err_o, byteenable_o,
                     address_o, writedata_o};
            exp_v = {!we, we, 1'b1, 1'b0, 1'b0, m_be(sz, a),
                     {a[31:2], 2'b00}, m_wd(sz, wd)};
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL %s bus cycle %0d: got %h want %h", tag, j, act_v, exp_v);
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        waitrequest_i = 1'b1;
        #1;
        n_total++;
        if ({done_o, stall_o, read_o, write_o, err_o, byteenable_o} !== 9'b1_0000_0000)
            $display("FAIL %s response: done/stall/rd/wr/err/be got %b want 100000000",
                     tag, {done_o, stall_o, read_o, write_o, err_o, byteenable_o});
        else n_pass++;
        if (!we) begin
            model_rdata = m_load(sz, sg, a, rd);
            n_total++;
            if (rdata_o !== model_rdata)
                $display("FAIL %s rdata: got %h want %h", tag, rdata_o, model_rdata);
            else n_pass++;
        end
        @(posedge clk); @(negedge clk);
        n_total++;
        if ({done_o, stall_o} !== 2'b00)
            $display("FAIL %s after response: done/stall got %b want 00", tag,
                     {done_o, stall_o});
        else n_pass++;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        reset_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0;
        sign_ext_i = 1'b0; addr_i = '0; wdata_i = '0;
        waitrequest_i = 1'b0; readdata_i = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({stall_o, done_o, misalign_o, err_o, read_o, write_o, byteenable_o,
             address_o, writedata_o, rdata_o} !== '0)
            $display("FAIL reset outputs: got %h want 0",
                     {stall_o, done_o, misalign_o, err_o, read_o, write_o,
                      byteenable_o, address_o, writedata_o, rdata_o});
        else n_pass++;
        reset_n_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_access(1'b0, 2, 1'b0, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF, "lw");
        do_access(1'b0, 0, 1'b1, 32'h0000_1003, 32'h0, 0, 32'h80FF_FFFF, "lb");
        do_access(1'b0, 0, 1'b0, 32'h0000_1003, 32'h0, 0, 32'h80FF_FFFF, "lbu");
        do_access(1'b1, 1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 3, 32'h0, "sh");
        do_access(1'b0, 1, 1'b1, 32'h0000_2002, 32'h0, 1, 32'h8123_4567, "lh");
        do_access(1'b1, 0, 1'b0, 32'h0000_3001, 32'h1234_5678, 0, 32'h0, "sb");
        do_access(1'b1, 2, 1'b0, 32'h0000_3008, 32'hCAFE_F00D, 2, 32'h0, "sw");
    endtask

    task automatic test_misalign();
        do_access(1'b0, 2, 1'b0, 32'h0000_1002, 32'h0, 0, 32'h0, "lw_mis");
        do_access(1'b1, 1, 1'b0, 32'h0000_1001, 32'hFFFF, 0, 32'h0, "sh_mis");
        // rdata must be untouched by rejected requests
        n_total++;
        if (rdata_o !== model_rdata)
            $display("FAIL misalign rdata hold: got %h want %h", rdata_o, model_rdata);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          sz;
            logic [31:0] a;
            sz = $urandom_range(0, 2);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~32'(sz == 2 ? 3 : (sz == 1 ? 1 : 0));
            do_access(1'($urandom), sz, 1'($urandom), a, $urandom,
                      $urandom_range(0, 3), $urandom, "rand");
        end
    endtask

    task automatic test_reset_mid_bus();
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sign_ext_i = 1'b0;
        addr_i = 32'h0000_5000; waitrequest_i = 1'b1;
        @(posedge clk); @(negedge clk);
        req_i = 1'b0;
        #1;
        n_total++;
        if ({read_o, stall_o} !== 2'b11)
            $display("FAIL midbus pre-reset: rd/stall got %b want 11", {read_o, stall_o});
        else n_pass++;
        #2 reset_n_i = 1'b0;
        #1;
        n_total++;
        if ({read_o, stall_o, address_o, byteenable_o, rdata_o} !== '0)
            $display("FAIL midbus async reset: got %h want 0",
                     {read_o, stall_o, address_o, byteenable_o, rdata_o});
        else n_pass++;
        model_rdata = '0;
        @(posedge clk); @(negedge clk);
        reset_n_i = 1'b1;
        @(posedge clk); @(negedge clk);
        n_total++;
        if ({read_o, write_o, stall_o, done_o} !== 4'b0000)
            $display("FAIL midbus after release: rd/wr/stall/done got %b want 0000",
                     {read_o, write_o, stall_o, done_o});
        else n_pass++;
        do_access(1'b0, 2, 1'b0, 32'h0000_5004, 32'h0, 0, 32'h0BAD_CAFE, "post_rst");
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] held;
        held = model_rdata;
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_4000;
        waitrequest_i = 1'b1;
        @(posedge clk); @(negedge clk);
        req_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_total++;
            if ({read_o, err_o, done_o} !== 3'b100)
                $display("FAIL timeout wait %0d: rd/err/done got %b want 100", j,
                         {read_o, err_o, done_o});
            else n_pass++;
            @(posedge clk); @(negedge clk);
        end
        #1;
        n_total++;
        if ({read_o, err_o, done_o, stall_o, rdata_o} !== {4'b0100, held})
            $display("FAIL timeout abort: got %h want %h",
                     {read_o, err_o, done_o, stall_o, rdata_o}, {4'b0100, held});
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++;
        if ({read_o, err_o, done_o} !== 3'b000)
            $display("FAIL timeout after: rd/err/done got %b want 000",
                     {read_o, err_o, done_o});
        else n_pass++;
        waitrequest_i = 1'b0;
    endtask
`else
    task automatic test_timeout();
        // Without the timeout a long stall must simply keep waiting.
        do_access(1'b0, 2, 1'b0, 32'h0000_4000, 32'h0, 20, 32'h1357_9BDF, "longwait");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_random();
        test_reset_mid_bus();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
